// File: rtl/wishbone_sram_controller.sv
// Wishbone slave fronting one port of a synchronous single-port SRAM macro.
// Handles one transaction at a time. The byte address is decoded to a word
// index and range-checked. Strobes to the SRAM are registered. The transfer
// finishes with either a one-cycle ack (read data valid in that cycle) or a
// one-cycle error.
//
// Ports:
//   wb_clk_i, wb_rst_n_i       clock, async active-low reset
//   wb_cyc_i/stb_i/we_i        bus handshake and direction
//   wb_sel_i, wb_data_i        byte enables, write data
//   wb_adr_i                   24-bit byte address
//   wb_ack_o/error_o/stall_o   completion, failure, back-pressure
//   wb_data_o                  read data (held until the next read completes)
//   sram_*                     SRAM macro port (active-low csb/web)
//   probe_state                current FSM state for debug
module wishbone_sram_controller #(
  parameter int ADDR_WIDTH   = 9,
  parameter int SIZE_WORDS   = 512,
  parameter int READ_LATENCY = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_data_i,
  input  logic [23:0]           wb_adr_i,
  output logic                  wb_ack_o,
  output logic                  wb_stall_o,
  output logic                  wb_error_o,
  output logic [31:0]           wb_data_o,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [3:0]            sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [31:0]           sram_din0,
  input  logic [31:0]           sram_dout0,
  output logic [2:0]            probe_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WRITE    = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_RESPOND  = 3'd4,
    S_ERROR    = 3'd5
  } state_e;

  localparam logic [ADDR_WIDTH:0] SIZE_L   = (ADDR_WIDTH+1)'(SIZE_WORDS);
  localparam logic [2:0]          LAT_LAST = 3'(READ_LATENCY - 1);

  state_e                state_q;
  logic [2:0]            cnt_q;
  logic                  ack_q, err_q, csb_q, web_q;
  logic [31:0]           rdata_q, din_q;
  logic [3:0]            wmask_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  // Address decode. Byte offset bits are don't-care for a word-wide SRAM.
  logic [ADDR_WIDTH-1:0] idx;
  logic                  hi_nz, idx_oor, bad, accept;
  logic                  unused_adr;

  assign idx        = wb_adr_i[ADDR_WIDTH+1:2];
  assign hi_nz      = |wb_adr_i[23:ADDR_WIDTH+2];
  assign idx_oor    = {1'b0, idx} >= SIZE_L;
  // A write with no byte lanes enabled is meaningless and is rejected.
  assign bad        = hi_nz | idx_oor | (wb_we_i & ~|wb_sel_i);
  assign accept     = (state_q == S_IDLE) & wb_cyc_i & wb_stb_i;
  assign unused_adr = ^wb_adr_i[1:0];

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      // Pulses and strobes default inactive; only the entry edges raise them.
      ack_q <= 1'b0;
      err_q <= 1'b0;
      csb_q <= 1'b1;
      web_q <= 1'b1;
      case (state_q)
        S_IDLE: if (accept) begin
          if (bad) begin
            state_q <= S_ERROR;
            err_q   <= 1'b1;
          end else begin
            addr_q  <= idx;
            din_q   <= wb_data_i;
            wmask_q <= wb_sel_i;
            csb_q   <= 1'b0;
            web_q   <= ~wb_we_i;
            state_q <= wb_we_i ? S_WRITE : S_RD_ISSUE;
          end
        end
        // A dropped cyc aborts silently; a write already strobed stands.
        S_WRITE: begin
          if (!wb_cyc_i) state_q <= S_IDLE;
          else begin
            state_q <= S_RESPOND;
            ack_q   <= 1'b1;
          end
        end
        S_RD_ISSUE: begin
          if (!wb_cyc_i) state_q <= S_IDLE;
          else begin
            state_q <= S_RD_WAIT;
            cnt_q   <= '0;
          end
        end
        S_RD_WAIT: begin
          if (!wb_cyc_i) state_q <= S_IDLE;
          else if (cnt_q == LAT_LAST) begin
            rdata_q <= sram_dout0;
            ack_q   <= 1'b1;
            state_q <= S_RESPOND;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wb_ack_o    = ack_q;
  assign wb_error_o  = err_q;
  assign wb_data_o   = rdata_q;
  assign wb_stall_o  = (state_q != S_IDLE);
  assign sram_csb0   = csb_q;
  assign sram_web0   = web_q;
  assign sram_wmask0 = wmask_q;
  assign sram_addr0  = addr_q;
  assign sram_din0   = din_q;
  assign probe_state = state_q;

endmodule

// File: doc/wishbone_sram_controller.md
Name: wishbone_sram_controller

Overview:
Wishbone slave that consumes the single arbitrated bus produced by the multi-master slave mux and drives one port of a synchronous single-port SRAM macro. It decodes the 24-bit byte address to a word index, range-checks it and issues registered SRAM strobes. It returns ack or error with the SRAM read data. One transaction is in flight at a time; back-pressure uses wb_stall_o.

Parameters:
ADDR_WIDTH, 9, SRAM word-address width.
SIZE_WORDS, 512, implemented words; valid word indices are 0..SIZE_WORDS-1 (SIZE_WORDS <= 2^ADDR_WIDTH).
READ_LATENCY, 1, cycles from SRAM strobe to valid sram_dout0 (range 1..7).

Ports:
wb_clk_i  in  1  system clock, all logic on rising edge
wb_rst_n_i  in  1  asynchronous active-low reset
wb_cyc_i  in  1  bus cycle active
wb_stb_i  in  1  transfer strobe
wb_we_i  in  1  1 = write
wb_sel_i  in  4  byte lane enables
wb_data_i  in  32  write data
wb_adr_i  in  24  byte address
wb_ack_o  out  1  transfer complete
wb_stall_o  out  1  request not accepted this cycle
wb_error_o  out  1  transfer failed
wb_data_o  out  32  read data
sram_csb0  out  1  chip select, active low
sram_web0  out  1  write enable, active low
sram_wmask0  out  4  byte write mask
sram_addr0  out  ADDR_WIDTH  word address
sram_din0  out  32  SRAM write data
sram_dout0  in  32  SRAM read data
probe_state  out  3  current FSM state encoding

Behaviour:
- Reset (async assert, sync release) sets:
  - outputs: wb_ack_o=0, wb_error_o=0, wb_data_o=0, wb_stall_o=0, sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0.
  - state: IDLE, wait counter=0.
- wb_stall_o is combinational: 1 whenever state != IDLE, else 0.
- Accept condition: state==IDLE and wb_cyc_i and wb_stb_i, in cycle T. Address, data, sel and we are captured at the end of T.
- Word index = wb_adr_i[ADDR_WIDTH+1:2]; wb_adr_i[1:0] is ignored.
- Out of range if wb_adr_i[23:ADDR_WIDTH+2] != 0 or word index >= SIZE_WORDS. Reads with wb_sel_i=0 are valid; writes with wb_sel_i=0 are errors.
- States:
  - IDLE.
  - WRITE: sram_csb0=0, sram_web0=0, wmask=sel, addr/din registered; exactly 1 cycle (T+1).
  - READ_ISSUE: sram_csb0=0, sram_web0=1, 1 cycle (T+1).
  - READ_WAIT: counter counts READ_LATENCY cycles. In its final cycle, wb_data_o is registered from sram_dout0.
  - RESPOND: wb_ack_o=1 for exactly one cycle.
  - ERROR: wb_error_o=1 for exactly one cycle, no SRAM strobe.
- Transitions:
  - IDLE -> ERROR on an out-of-range accept, else WRITE or READ_ISSUE.
  - WRITE -> RESPOND.
  - READ_ISSUE -> READ_WAIT -> RESPOND.
  - RESPOND and ERROR -> IDLE.
- SRAM strobes are high (inactive) in every state except WRITE and READ_ISSUE.
- Latency from accept cycle T:
  - Write ack at T+2.
  - Read ack at T+2+READ_LATENCY (T+3 default), with wb_data_o valid in the ack cycle.
  - Error at T+1.
  - Next accept at the earliest one cycle after the ack/error cycle.
- wb_data_o holds its last read value until the next read completes; it is unchanged by writes and errors.
- ack and error are never both 1.
- wb_cyc_i deasserted while state is READ_ISSUE or READ_WAIT, or while entering RESPOND/ERROR: abort.
  - FSM returns to IDLE next cycle; no ack or error is produced.
  - A write already strobed is not undone.
- Reset mid-transaction: outputs go to reset values immediately, with no ack.
- wb_stb_i without wb_cyc_i is ignored.
- probe_state encoding: IDLE=0, WRITE=1, READ_ISSUE=2, READ_WAIT=3, RESPOND=4, ERROR=5.

Test Plan:
- Write 0xDEADBEEF, sel=4'hF, adr=0x000010 at T -> T+1: csb0=0, web0=0, addr0=4, din0=0xDEADBEEF; ack at T+2 only; stall=1 during T+1..T+2.
- Read adr=0x000010 with SRAM model returning 0xDEADBEEF (READ_LATENCY=1) -> csb0=0 at T+1; ack=1 with wb_data_o=0xDEADBEEF at T+3; stall 0 at T+4.
- Partial write sel=4'b0010, data 0x0000AB00 to word 4, then read it back -> wmask0=4'b0010; readback 0xDEADABEF.
- Out-of-range accesses (error at T+1, no ack, csb0 stays 1):
  - read adr=0x000800 (word 512).
  - read adr=0x100000.
  - write sel=0 to adr=0.
- Issue read, drop wb_cyc_i during READ_WAIT -> no ack or error; FSM IDLE next cycle; an immediate following write is accepted and acked normally.
- Assert wb_rst_n_i=0 during READ_WAIT -> all outputs at reset values in the same cycle; probe_state=0; no ack after release.
